// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: redirect/trap inputs, instruction-memory port, decode handshake and perf outputs.
// The fetch controller connects through the master modport, the pipeline/memory side through slave.
interface fetch_ctrl_if #(
    parameter int REG_SIZE = 32
);
    logic                redirect_i;
    logic [REG_SIZE-1:0] redirect_pc_i;
    logic                trap_i;
    logic [REG_SIZE-1:0] trap_pc_i;
    logic                id_ready_i;
    logic [REG_SIZE-1:0] imem_addr_o;
    logic [REG_SIZE-1:0] imem_inst_i;
    logic                if_valid_o;
    logic [REG_SIZE-1:0] if_pc_o;
    logic [REG_SIZE-1:0] if_inst_o;
    logic                misalign_o;
    logic [31:0]         perf_fetch_cnt_o;
    logic [31:0]         perf_stall_cnt_o;

    modport master (
        input  redirect_i, redirect_pc_i, trap_i, trap_pc_i, id_ready_i, imem_inst_i,
        output imem_addr_o, if_valid_o, if_pc_o, if_inst_o, misalign_o,
               perf_fetch_cnt_o, perf_stall_cnt_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, trap_i, trap_pc_i, id_ready_i, imem_inst_i,
        input  imem_addr_o, if_valid_o, if_pc_o, if_inst_o, misalign_o,
               perf_fetch_cnt_o, perf_stall_cnt_o
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, decode handshake with a one-entry hold buffer,
// redirect/trap kill. Macro FETCH_PERF_EN builds the fetch/stall counters; otherwise they read 0.
module fetch_ctrl #(
    parameter int                  REG_SIZE = 32,
    parameter logic [REG_SIZE-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

    state_t              state_q, state_d;
    logic [REG_SIZE-1:0] pc_q, pc_d;
    logic [REG_SIZE-1:0] hold_inst_q, hold_inst_d;
    logic [REG_SIZE-1:0] target;
    logic [REG_SIZE-1:0] inst;
    logic                valid;
    logic                flush;
    logic                misalign_q, misalign_d;

    function automatic logic [REG_SIZE-1:0] align_pc(input logic [REG_SIZE-1:0] addr);
        return {addr[REG_SIZE-1:2], 2'b00};
    endfunction

    function automatic logic [REG_SIZE-1:0] next_pc(input logic [REG_SIZE-1:0] addr);
        return addr + REG_SIZE'(4);
    endfunction

    // Trap has priority over a simultaneous branch redirect.
    assign flush      = bus.trap_i | bus.redirect_i;
    assign target     = bus.trap_i ? bus.trap_pc_i : bus.redirect_pc_i;
    assign misalign_d = bus.redirect_i & ~bus.trap_i & bus.redirect_pc_i[1];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_inst_d = hold_inst_q;
        valid       = 1'b0;
        inst        = bus.imem_inst_i;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                valid = 1'b1;
                if (bus.id_ready_i) begin
                    pc_d = next_pc(pc_q);
                end else begin
                    hold_inst_d = bus.imem_inst_i;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                valid = 1'b1;
                inst  = hold_inst_q;
                if (bus.id_ready_i) begin
                    pc_d    = next_pc(pc_q);
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
        // Wrong-path kill: the offered instruction is dropped and any held one is abandoned.
        if (flush) begin
            valid   = 1'b0;
            pc_d    = align_pc(target);
            state_d = FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            hold_inst_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_inst_q <= hold_inst_d;
            misalign_q  <= misalign_d;
        end
    end

    assign bus.imem_addr_o = pc_q;
    assign bus.if_pc_o     = pc_q;
    assign bus.if_inst_o   = inst;
    assign bus.if_valid_o  = valid;
    assign bus.misalign_o  = misalign_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (valid && bus.id_ready_i) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (valid && !bus.id_ready_i) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign bus.perf_fetch_cnt_o = fetch_cnt_q;
    assign bus.perf_stall_cnt_o = stall_cnt_q;
`else
    assign bus.perf_fetch_cnt_o = '0;
    assign bus.perf_stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: behavioural model compared every cycle plus literal pins.
// A second instance with RESET_PC at the top of the address space covers PC wrap-around.
module tb_fetch_ctrl;
    localparam bit PERF = `ifdef FETCH_PERF_EN 1'b1 `else 1'b0 `endif;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] noise = 32'h0;
    int          checks   = 0;
    int          failures = 0;

    fetch_ctrl_if #(.REG_SIZE(32)) bus ();
    fetch_ctrl_if #(.REG_SIZE(32)) bus2 ();

    fetch_ctrl #(.REG_SIZE(32), .RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    fetch_ctrl #(.REG_SIZE(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Combinational instruction memory; noise lets the bench change the returned word mid-stall.
    assign bus.imem_inst_i = mem_fn(bus.imem_addr_o) ^ noise;

    assign bus2.redirect_i    = 1'b0;
    assign bus2.redirect_pc_i = 32'h0;
    assign bus2.trap_i        = 1'b0;
    assign bus2.trap_pc_i     = 32'h0;
    assign bus2.id_ready_i    = 1'b1;
    assign bus2.imem_inst_i   = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: program counter, whether the fetch unit is still booting, and the held word if any.
    logic [31:0] m_pc       = 32'h0;
    logic        m_booting  = 1'b1;
    logic        m_held     = 1'b0;
    logic [31:0] m_held_val = 32'h0;
    logic        m_mis      = 1'b0;
    logic [31:0] m_fc       = 32'h0;
    logic [31:0] m_sc       = 32'h0;
    logic [31:0] m_tgt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 32'h0; m_booting = 1'b1; m_held = 1'b0; m_held_val = 32'h0;
            m_mis = 1'b0; m_fc = 32'h0; m_sc = 32'h0;
        end else begin
            m_mis = bus.redirect_i && !bus.trap_i && bus.redirect_pc_i[1];
            m_tgt = bus.trap_i ? bus.trap_pc_i : bus.redirect_pc_i;
            if (bus.trap_i || bus.redirect_i) begin
                m_pc = {m_tgt[31:2], 2'b00};
                m_held = 1'b0;
                m_booting = 1'b0;
            end else if (m_booting) begin
                m_booting = 1'b0;
            end else if (bus.id_ready_i) begin
                m_fc = m_fc + 32'd1;
                m_pc = m_pc + 32'd4;
                m_held = 1'b0;
            end else begin
                m_sc = m_sc + 32'd1;
                if (!m_held) begin
                    m_held = 1'b1;
                    m_held_val = mem_fn(m_pc) ^ noise;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic exp_valid;
        exp_valid = rst_n && !m_booting && !(bus.trap_i || bus.redirect_i);
        chk("m_valid", bus.if_valid_o, exp_valid);
        chk("m_pc", bus.if_pc_o, m_pc);
        chk("m_addr", bus.imem_addr_o, m_pc);
        if (exp_valid) chk("m_inst", bus.if_inst_o, m_held ? m_held_val : (mem_fn(m_pc) ^ noise));
        chk("m_misalign", bus.misalign_o, m_mis);
        chk("m_perf_fetch", bus.perf_fetch_cnt_o, PERF ? m_fc : 32'h0);
        chk("m_perf_stall", bus.perf_stall_cnt_o, PERF ? m_sc : 32'h0);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] pattern;
        pattern = 12'b1011_0010_0110;
        bus.redirect_i = 1'b0; bus.redirect_pc_i = 32'h0;
        bus.trap_i = 1'b0; bus.trap_pc_i = 32'h0; bus.id_ready_i = 1'b1;
        #1 rst_n = 1'b0;
        next_cycle; next_cycle; #2;
        chk("rst_valid", bus.if_valid_o, 1'b0);
        chk("rst_pc", bus.if_pc_o, 32'h0);
        chk("rst_misalign", bus.misalign_o, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("boot_valid", bus.if_valid_o, 1'b0);
        chk("boot_valid2", bus2.if_valid_o, 1'b0);
        next_cycle; #2;
        chk("pc0", bus.if_pc_o, 32'h0);
        chk("pc0_valid", bus.if_valid_o, 1'b1);
        chk("wrap_pc_top", bus2.if_pc_o, 32'hFFFF_FFFC);
        chk("wrap_valid_top", bus2.if_valid_o, 1'b1);
        next_cycle; #2;
        chk("pc4", bus.if_pc_o, 32'h4);
        chk("wrap_pc_zero", bus2.if_pc_o, 32'h0);
        chk("wrap_valid_zero", bus2.if_valid_o, 1'b1);
        // Stall at pc=8 for three cycles while memory output changes.
        next_cycle;
        noise = 32'h1111_0000; bus.id_ready_i = 1'b0; #2;
        chk("pc8", bus.if_pc_o, 32'h8);
        chk("inst8", bus.if_inst_o, 32'h1119_FFF7);
        next_cycle;
        noise = 32'h2222_0000; #2;
        chk("hold1_inst", bus.if_inst_o, 32'h1119_FFF7);
        chk("hold1_pc", bus.if_pc_o, 32'h8);
        next_cycle;
        noise = 32'h3333_0000; #2;
        chk("hold2_inst", bus.if_inst_o, 32'h1119_FFF7);
        next_cycle;
        bus.id_ready_i = 1'b1; #2;
        chk("hold3_inst", bus.if_inst_o, 32'h1119_FFF7);
        chk("hold3_pc", bus.if_pc_o, 32'h8);
        chk("stall_cnt", bus.perf_stall_cnt_o, PERF ? 32'd3 : 32'd0);
        next_cycle; #2;
        chk("pc12", bus.if_pc_o, 32'hC);
        chk("fetch_cnt", bus.perf_fetch_cnt_o, PERF ? 32'd3 : 32'd0);
        // Trap and redirect together: trap wins.
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h100;
        bus.trap_i = 1'b1; bus.trap_pc_i = 32'h80; #1;
        chk("both_kill", bus.if_valid_o, 1'b0);
        next_cycle;
        bus.redirect_i = 1'b0; bus.trap_i = 1'b0; #2;
        chk("trap_pc", bus.if_pc_o, 32'h80);
        chk("trap_mis", bus.misalign_o, 1'b0);
        // Misaligned redirect target.
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0000_0206; #1;
        chk("redir_kill", bus.if_valid_o, 1'b0);
        next_cycle;
        bus.redirect_i = 1'b0; #2;
        chk("redir_pc", bus.if_pc_o, 32'h204);
        chk("redir_mis", bus.misalign_o, 1'b1);
        next_cycle; #2;
        chk("redir_pc_next", bus.if_pc_o, 32'h208);
        chk("redir_mis_clear", bus.misalign_o, 1'b0);
        // Redirect while holding discards the held word.
        bus.id_ready_i = 1'b0;
        next_cycle;
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h300; #1;
        chk("hold_kill", bus.if_valid_o, 1'b0);
        next_cycle;
        bus.redirect_i = 1'b0; bus.id_ready_i = 1'b1; #2;
        chk("hold_redir_pc", bus.if_pc_o, 32'h300);
        chk("hold_redir_inst", bus.if_inst_o, 32'h3033_FCFF);
        // Trap target with bit 1 set aligns but never flags misalignment.
        bus.trap_i = 1'b1; bus.trap_pc_i = 32'h42;
        next_cycle;
        bus.trap_i = 1'b0; #2;
        chk("trap42_pc", bus.if_pc_o, 32'h40);
        chk("trap42_mis", bus.misalign_o, 1'b0);
        for (int i = 0; i < 12; i++) begin
            bus.id_ready_i = pattern[i];
            next_cycle;
        end
        // Asynchronous reset in the middle of a hold.
        bus.id_ready_i = 1'b0;
        next_cycle; next_cycle; #2;
        rst_n = 1'b0; #1;
        chk("areset_valid", bus.if_valid_o, 1'b0);
        chk("areset_pc", bus.if_pc_o, 32'h0);
        chk("areset_fetch_cnt", bus.perf_fetch_cnt_o, 32'h0);
        chk("areset_stall_cnt", bus.perf_stall_cnt_o, 32'h0);
        bus.id_ready_i = 1'b1;
        next_cycle; next_cycle;
        rst_n = 1'b1; #1;
        chk("areset_boot", bus.if_valid_o, 1'b0);
        next_cycle; #2;
        chk("areset_fetch_pc", bus.if_pc_o, 32'h0);
        chk("areset_fetch_valid", bus.if_valid_o, 1'b1);
        // Redirect taken while booting.
        rst_n = 1'b0; #1;
        rst_n = 1'b1;
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h502; #1;
        chk("boot_redir_valid", bus.if_valid_o, 1'b0);
        next_cycle;
        bus.redirect_i = 1'b0; #2;
        chk("boot_redir_pc", bus.if_pc_o, 32'h500);
        chk("boot_redir_mis", bus.misalign_o, 1'b1);
        chk("boot_redir_valid2", bus.if_valid_o, 1'b1);
        next_cycle; next_cycle;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
